// File: rtl/ps2_frame_receiver_if.sv
// Pin and result bundle between a PS/2 frame receiver and its consumer.
// The master side is the receiver; the slave side drives the pins and takes the bytes.
interface ps2_frame_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       scan_code_ready;
    logic [7:0] scan_code;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    modport master (
        input  ps2_clk, ps2_data,
        output scan_code_ready, scan_code, parity_error, frame_error, busy
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  scan_code_ready, scan_code, parity_error, frame_error, busy
    );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: pin sync, ps2_clk glitch filter, 11-bit frame FSM.
// Optional in-frame idle timeout is built only when PS2_RX_TIMEOUT_EN is defined.
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 21600
) (
    input  logic                   clk,
    input  logic                   reset,
    ps2_frame_receiver_if.master   bus
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

    logic       clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic       data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic [3:0] filt_cnt_q, filt_cnt_d;
    logic       filt_clk_q, filt_clk_d;
    logic       sample_evt;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic [7:0] scan_code_q, scan_code_d;
    logic       ready_q, ready_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       timeout_hit;

    always_comb begin
        clk_s1_d  = bus.ps2_clk;
        clk_s2_d  = clk_s1_q;
        data_s1_d = bus.ps2_data;
        data_s2_d = data_s1_q;
    end

    // Filtered clock follows the synced pin only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_cnt_d = filt_cnt_q;
        filt_clk_d = filt_clk_q;
        if (clk_s2_q == filt_clk_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_LAST) begin
            filt_clk_d = clk_s2_q;
            filt_cnt_d = '0;
        end else if (filt_cnt_q != 4'hF) begin
            filt_cnt_d = filt_cnt_q + 4'd1;
        end
        sample_evt = filt_clk_q & ~filt_clk_d;
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d    = to_cnt_q;
        timeout_hit = 1'b0;
        if (state_q == S_IDLE || sample_evt) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            timeout_hit = 1'b1;
            to_cnt_d    = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        scan_code_d = scan_code_q;
        ready_d     = 1'b0;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        if (sample_evt) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    parity_d = data_s2_q;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!data_s2_q) begin
                        ferr_d = 1'b1;
                    end else if (^{shift_q, parity_q}) begin
                        scan_code_d = shift_q;
                        ready_d     = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Timeout only fires in cycles without a sample event, so it never collides with a result.
        if (timeout_hit) begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            data_s1_q   <= 1'b1;
            data_s2_q   <= 1'b1;
            filt_cnt_q  <= '0;
            filt_clk_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            scan_code_q <= '0;
            ready_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            data_s1_q   <= data_s1_d;
            data_s2_q   <= data_s2_d;
            filt_cnt_q  <= filt_cnt_d;
            filt_clk_q  <= filt_clk_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            scan_code_q <= scan_code_d;
            ready_q     <= ready_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign bus.scan_code_ready = ready_q;
    assign bus.scan_code       = scan_code_q;
    assign bus.parity_error    = perr_q;
    assign bus.frame_error     = ferr_q;
    assign bus.busy            = (state_q != S_IDLE);

endmodule
